// File: rtl/sblock_cfg_loader.sv
// Deserialises a config bitstream into per-block words; word visible at WRITE 1 cycle after its last bit.
// Backpressure: cfg_ready drops during WRITE/IDLE; a stalled cfg_valid holds all state.
module sblock_cfg_loader #(
   parameter int N_BLK   = 4,
   parameter int SB_BITS = 18
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic               cfg_valid,
   input  logic               cfg_bit,
   output logic               cfg_ready,
   output logic [SB_BITS-1:0] sb_bits,
   output logic [N_BLK-1:0]   sb_wr_en,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int BW = (N_BLK > 1) ? $clog2(N_BLK) : 1;
   localparam int CW = $clog2(SB_BITS);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_CHECK = 2'd3;

   logic [1:0]    state;
   logic [BW-1:0] blk_idx;
   logic [CW-1:0] bit_cnt;
   logic          parity;
   logic          xfer;

   // Handshake and write strobes are pure state decode so an abort never truncates a WRITE cycle.
   assign cfg_ready = (state == S_SHIFT) || (state == S_CHECK);
   assign sb_wr_en  = (state == S_WRITE) ? (N_BLK'(1) << blk_idx) : '0;
   assign busy      = (state != S_IDLE);
   assign xfer      = cfg_valid && cfg_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         sb_bits <= '0;
         blk_idx <= '0;
         bit_cnt <= '0;
         parity  <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else if (state == S_IDLE) begin
         if (start) begin
            state   <= S_SHIFT;
            done    <= 1'b0;
            err     <= 1'b0;
            blk_idx <= '0;
            bit_cnt <= '0;
            parity  <= 1'b0;
         end
      end else if (abort) begin
         state <= S_IDLE;
         err   <= 1'b1;
         done  <= 1'b0;
      end else begin
         case (state)
            S_SHIFT: begin
               if (xfer) begin
                  sb_bits <= {sb_bits[SB_BITS-2:0], cfg_bit};
                  parity  <= parity ^ cfg_bit;
                  bit_cnt <= bit_cnt + CW'(1);
                  if (bit_cnt == CW'(SB_BITS - 1)) state <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (blk_idx == BW'(N_BLK - 1)) begin
                  state <= S_CHECK;
               end else begin
                  blk_idx <= blk_idx + BW'(1);
                  bit_cnt <= '0;
                  state   <= S_SHIFT;
               end
            end
            default: begin
               // Trailing parity bit: compared only, never shifted into sb_bits.
               if (xfer) begin
                  state <= S_IDLE;
                  if (cfg_bit != parity) err  <= 1'b1;
                  else                   done <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sblock_cfg_loader.sv
// Randomised bench for sblock_cfg_loader: scoreboard of expected block writes and final status per load.
module tb_sblock_cfg_loader;

   localparam int NB  = 4;
   localparam int SBW = 18;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic           abort = 1'b0;
   logic           cfg_valid = 1'b0;
   logic           cfg_bit = 1'b0;
   logic           cfg_ready;
   logic [SBW-1:0] sb_bits;
   logic [NB-1:0]  sb_wr_en;
   logic           busy;
   logic           done;
   logic           err;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   sblock_cfg_loader #(.N_BLK(NB), .SB_BITS(SBW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .cfg_valid (cfg_valid),
      .cfg_bit   (cfg_bit),
      .cfg_ready (cfg_ready),
      .sb_bits   (sb_bits),
      .sb_wr_en  (sb_wr_en),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One complete load. Cycle n is the period after clock edge n-1; start is applied in cycle 0.
   task automatic run_load(input logic [SBW-1:0] w0, input logic [SBW-1:0] w1,
                           input logic [SBW-1:0] w2, input logic [SBW-1:0] w3,
                           input bit flip, input int gap_pct, input int abort_wr,
                           input bit mid_start, input bit exact);
      logic [SBW-1:0] words [NB];
      bit             bits [$];
      int             exp_blk [$];
      logic [SBW-1:0] exp_word [$];
      bit             good;
      bit             aborted;
      int             cyc;
      int             nwr;
      int             abort_cyc;
      int             exp_nwr;

      words = '{w0, w1, w2, w3};
      good = 1'b0;
      aborted = (abort_wr >= 0);
      exp_nwr = aborted ? abort_wr : NB;
      for (int k = 0; k < NB; k++) begin
         for (int b = SBW - 1; b >= 0; b--) begin
            bits.push_back(words[k][b]);
            good ^= words[k][b];
         end
         if (k < exp_nwr) begin
            exp_blk.push_back(k);
            exp_word.push_back(words[k]);
         end
      end
      bits.push_back(good ^ flip);

      @(negedge clk);
      start = 1'b1;
      abort = 1'b0;
      cfg_valid = 1'b0;
      cyc = 0;
      nwr = 0;
      abort_cyc = -1;
      while (cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            chk("start_clr_err", err, 0);
            chk("start_clr_done", done, 0);
            chk("start_busy", busy, 1);
         end
         if (sb_wr_en != '0) begin
            chk("wr_onehot", 32'($onehot(sb_wr_en)), 1);
            if (exp_blk.size() == 0) begin
               chk("wr_extra", sb_wr_en, 0);
            end else begin
               chk("wr_blk", sb_wr_en, 32'(1) << exp_blk.pop_front());
               chk("wr_word", sb_bits, exp_word.pop_front());
               if (exact) chk("wr_cycle", cyc, 19 * (nwr + 1));
            end
            nwr++;
            if (nwr == abort_wr) abort_cyc = cyc + 1;
         end
         if (!busy) break;
         start = mid_start && (cyc == 5);
         abort = (cyc == abort_cyc);
         cfg_valid = ($urandom_range(99) >= gap_pct);
         cfg_bit = (bits.size() > 0) ? bits[0] : 1'b0;
         if (cfg_valid && cfg_ready && !abort && bits.size() > 0) bits.pop_front();
      end
      start = 1'b0;
      abort = 1'b0;
      cfg_valid = 1'b0;

      chk("end_busy", busy, 0);
      chk("end_err", err, 32'(flip || aborted));
      chk("end_done", done, 32'(!(flip || aborted)));
      chk("wr_count", nwr, exp_nwr);
      if (aborted)    chk("abort_idle_cycle", cyc, abort_cyc + 1);
      else if (exact) chk("end_cycle", cyc, 19 * NB + 2);
   endtask

   function automatic logic [SBW-1:0] rnd_word();
      return SBW'($urandom());
   endfunction

   initial begin
      // Reset state and idle handshake
      repeat (3) @(negedge clk);
      chk("rst_ready", cfg_ready, 0);
      chk("rst_wr_en", sb_wr_en, 0);
      chk("rst_sb_bits", sb_bits, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_ready", cfg_ready, 0);
      end

      run_load(18'h3FFFF, 18'h00000, 18'h2AAAA, 18'h15555, 1'b0, 0, -1, 1'b0, 1'b1);

      // Abort while idle leaves the sticky status alone
      @(negedge clk);
      abort = 1'b1;
      repeat (2) @(negedge clk);
      abort = 1'b0;
      chk("idle_abort_err", err, 0);
      chk("idle_abort_done", done, 1);
      chk("idle_abort_busy", busy, 0);

      run_load(18'h3FFFF, 18'h00000, 18'h2AAAA, 18'h15555, 1'b1, 0, -1, 1'b0, 1'b1);
      run_load(rnd_word(), rnd_word(), rnd_word(), rnd_word(), 1'b0, 0, 2, 1'b0, 1'b1);
      run_load(rnd_word(), rnd_word(), rnd_word(), rnd_word(), 1'b0, 0, -1, 1'b0, 1'b1);
      run_load(rnd_word(), rnd_word(), rnd_word(), rnd_word(), 1'b0, 20, -1, 1'b1, 1'b0);
      for (int n = 0; n < 12; n++) begin
         run_load(rnd_word(), rnd_word(), rnd_word(), rnd_word(),
                  1'($urandom_range(1)), 40, (n % 4 == 3) ? int'($urandom_range(NB - 1)) + 1 : -1,
                  1'b0, 1'b0);
      end

      // Asynchronous reset in the middle of a word
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cfg_valid = 1'b1;
      cfg_bit = 1'b1;
      repeat (6) @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_busy", busy, 0);
      chk("async_rst_ready", cfg_ready, 0);
      chk("async_rst_sb_bits", sb_bits, 0);
      chk("async_rst_wr_en", sb_wr_en, 0);
      chk("async_rst_done", done, 0);
      chk("async_rst_err", err, 0);
      cfg_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", cfg_ready, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
